// File: rtl/bsg_dramsim3_traffic_gen.sv
// Synthetic read/write request generator for one DRAMsim3 channel.
// Base-plus-stride addressing, periodic writes, credit-limited reads, bandwidth counters.
module bsg_dramsim3_traffic_gen #(
  parameter int channel_addr_width_p = 29,
  parameter int count_width_p        = 32,
  parameter int max_outstanding_p    = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic [count_width_p-1:0]        num_req_i,
  input  logic [channel_addr_width_p-1:0] base_addr_i,
  input  logic [channel_addr_width_p-1:0] stride_i,
  input  logic [count_width_p-1:0]        write_every_i,
  output logic                            v_o,
  output logic                            write_not_read_o,
  output logic [channel_addr_width_p-1:0] ch_addr_o,
  input  logic                            yumi_i,
  input  logic                            data_v_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [count_width_p-1:0]        reads_sent_o,
  output logic [count_width_p-1:0]        writes_sent_o,
  output logic [count_width_p-1:0]        reads_recv_o,
  output logic [count_width_p-1:0]        cycles_o
);

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [out_width_lp-1:0] max_out_lp = out_width_lp'(max_outstanding_p);
  localparam logic [count_width_p-1:0] one_lp = count_width_p'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                            state_r, state_n;
  logic                              v_r, v_n;
  logic                              wnr_r, wnr_n;
  logic [channel_addr_width_p-1:0]   addr_r, stride_r;
  logic [count_width_p-1:0]          num_req_r, write_every_r, write_every_n;
  logic [count_width_p-1:0]          wcnt_r, wcnt_n, issued_r;
  logic [count_width_p-1:0]          reads_sent_r, writes_sent_r, reads_recv_r, cycles_r;
  logic [out_width_lp-1:0]           outstanding_r, outstanding_n;
  logic                              error_r;
  logic                              start, accept, rd_accept, last_accept, active;

  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] x,
                                                       input logic en);
    return (en && !(&x)) ? x + one_lp : x;
  endfunction

  assign start       = start_i && (state_r == IDLE || state_r == DONE);
  assign accept      = v_r && yumi_i;
  assign rd_accept   = accept && !wnr_r;
  assign last_accept = accept && (issued_r == num_req_r - one_lp);
  assign active      = (state_r == ISSUE) || (state_r == DRAIN);

  // NOTE: every next-state term gets a default first so no latches are inferred.
  always_comb begin
    outstanding_n = outstanding_r;
    wcnt_n        = wcnt_r;
    write_every_n = write_every_r;
    state_n       = state_r;

    if (rd_accept && !data_v_i)
      outstanding_n = outstanding_r + out_width_lp'(1);
    else if (!rd_accept && data_v_i && outstanding_r != '0)
      outstanding_n = outstanding_r - out_width_lp'(1);

    if (accept)
      wcnt_n = wnr_r ? '0 : wcnt_r + one_lp;

    if (start) begin
      outstanding_n = '0;
      wcnt_n        = '0;
      write_every_n = write_every_i;
    end

    case (state_r)
      IDLE, DONE: if (start) state_n = (num_req_i == '0) ? DONE : ISSUE;
      ISSUE:      if (last_accept) state_n = (outstanding_n == '0) ? DONE : DRAIN;
      DRAIN:      if (outstanding_n == '0) state_n = DONE;
      default:    state_n = IDLE;
    endcase

    // Request valid/type are registered so they never depend on yumi_i combinationally.
    v_n   = (state_n == ISSUE) && (outstanding_n < max_out_lp);
    wnr_n = (state_n == ISSUE) && (write_every_n != '0) && (wcnt_n == write_every_n - one_lp);
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= IDLE;
      v_r           <= 1'b0;
      wnr_r         <= 1'b0;
      addr_r        <= '0;
      stride_r      <= '0;
      num_req_r     <= '0;
      write_every_r <= '0;
      wcnt_r        <= '0;
      issued_r      <= '0;
      outstanding_r <= '0;
      reads_sent_r  <= '0;
      writes_sent_r <= '0;
      reads_recv_r  <= '0;
      cycles_r      <= '0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_n;
      v_r           <= v_n;
      wnr_r         <= wnr_n;
      outstanding_r <= outstanding_n;
      wcnt_r        <= wcnt_n;
      write_every_r <= write_every_n;
      if (start) begin
        num_req_r     <= num_req_i;
        stride_r      <= stride_i;
        addr_r        <= base_addr_i;
        issued_r      <= '0;
        reads_sent_r  <= '0;
        writes_sent_r <= '0;
        reads_recv_r  <= '0;
        cycles_r      <= '0;
        error_r       <= 1'b0;
      end else begin
        if (accept) addr_r <= addr_r + stride_r;
        issued_r      <= sat_inc(issued_r, accept);
        reads_sent_r  <= sat_inc(reads_sent_r, rd_accept);
        writes_sent_r <= sat_inc(writes_sent_r, accept && wnr_r);
        reads_recv_r  <= sat_inc(reads_recv_r, data_v_i);
        cycles_r      <= sat_inc(cycles_r, active);
        // A return with nothing in flight (including strays from before a reset) is sticky.
        if (data_v_i && outstanding_r == '0) error_r <= 1'b1;
      end
    end
  end

  assign v_o              = v_r;
  assign write_not_read_o = wnr_r;
  assign ch_addr_o        = addr_r;
  assign busy_o           = active;
  assign done_o           = (state_r == DONE);
  assign error_o          = error_r;
  assign reads_sent_o     = reads_sent_r;
  assign writes_sent_o    = writes_sent_r;
  assign reads_recv_o     = reads_recv_r;
  assign cycles_o         = cycles_r;

endmodule

// File: tb/tb_bsg_dramsim3_traffic_gen.sv
// Directed bench for bsg_dramsim3_traffic_gen: streams, write interleave, credits, wrap, edges.
module tb_bsg_dramsim3_traffic_gen;

  localparam int aw = 29;
  localparam int cw = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, start_i, yumi_i, data_v_i;
  logic [cw-1:0] num_req_i, write_every_i;
  logic [aw-1:0] base_addr_i, stride_i;
  logic          v_o, write_not_read_o, busy_o, done_o, error_o;
  logic [aw-1:0] ch_addr_o;
  logic [cw-1:0] reads_sent_o, writes_sent_o, reads_recv_o, cycles_o;

  logic          c_start, c_data_v, c_yumi;
  logic          c_v, c_wnr, c_busy, c_done, c_error;
  logic [aw-1:0] c_addr;
  logic [cw-1:0] c_reads_sent, c_writes_sent, c_reads_recv, c_cycles;

  bsg_dramsim3_traffic_gen #(.channel_addr_width_p(aw), .count_width_p(cw), .max_outstanding_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .num_req_i(num_req_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .write_every_i(write_every_i),
    .v_o(v_o), .write_not_read_o(write_not_read_o), .ch_addr_o(ch_addr_o),
    .yumi_i(yumi_i), .data_v_i(data_v_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .reads_sent_o(reads_sent_o), .writes_sent_o(writes_sent_o),
    .reads_recv_o(reads_recv_o), .cycles_o(cycles_o));

  bsg_dramsim3_traffic_gen #(.channel_addr_width_p(aw), .count_width_p(cw), .max_outstanding_p(4)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .start_i(c_start), .num_req_i(num_req_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .write_every_i(write_every_i),
    .v_o(c_v), .write_not_read_o(c_wnr), .ch_addr_o(c_addr),
    .yumi_i(c_yumi), .data_v_i(c_data_v), .busy_o(c_busy), .done_o(c_done), .error_o(c_error),
    .reads_sent_o(c_reads_sent), .writes_sent_o(c_writes_sent),
    .reads_recv_o(c_reads_recv), .cycles_o(c_cycles));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc;
  int c_acc;
  bit auto_ret;
  bit ret_sched [256];

  int            log_n;
  logic [aw-1:0] log_addr [32];
  logic          log_wr   [32];
  int            log_cyc  [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive returns, log accepts, advance to the next negedge.
  task automatic step();
    data_v_i = ret_sched[8'(cyc)];
    ret_sched[8'(cyc)] = 1'b0;
    if (auto_ret && v_o && yumi_i && !write_not_read_o) ret_sched[8'(cyc + 5)] = 1'b1;
    if (v_o && yumi_i && log_n < 32) begin
      log_addr[log_n] = ch_addr_o;
      log_wr[log_n]   = write_not_read_o;
      log_cyc[log_n]  = cyc;
      log_n++;
    end
    if (c_v && c_yumi) c_acc++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run(input logic [cw-1:0] num, input logic [aw-1:0] base,
                           input logic [aw-1:0] stride, input logic [cw-1:0] we);
    num_req_i = num; base_addr_i = base; stride_i = stride; write_every_i = we;
    start_i = 1'b1;
    log_n = 0;
    start_cyc = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(done_o), 64'd1);
  endtask

  initial begin
    logic bad;
    reset_i = 1'b1; start_i = 1'b0; yumi_i = 1'b1; data_v_i = 1'b0;
    num_req_i = '0; base_addr_i = '0; stride_i = '0; write_every_i = '0;
    c_start = 1'b0; c_data_v = 1'b0; c_yumi = 1'b1;
    auto_ret = 1'b0; log_n = 0; c_acc = 0;
    foreach (ret_sched[i]) ret_sched[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;

    // Idle with no start: everything quiet.
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      bad |= v_o | write_not_read_o | busy_o | done_o | error_o | (|ch_addr_o) |
             (|reads_sent_o) | (|writes_sent_o) | (|reads_recv_o) | (|cycles_o);
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // Stray return in IDLE sets a sticky error.
    ret_sched[8'(cyc)] = 1'b1;
    step();
    check("stray_error", 64'(error_o), 64'd1);
    check("stray_recv", 64'(reads_recv_o), 64'd1);
    step(); step(); step();
    check("stray_sticky", 64'(error_o), 64'd1);

    // num_req = 0: DONE one cycle after start, error cleared by the start.
    start_run(0, 29'h55, 29'h4, 0);
    check("zero_done", 64'(done_o), 64'd1);
    check("zero_v", 64'(v_o), 64'd0);
    check("zero_busy", 64'(busy_o), 64'd0);
    check("zero_err_clr", 64'(error_o), 64'd0);
    check("zero_recv_clr", 64'(reads_recv_o), 64'd0);

    // Read stream: 8 reads back to back, returns 5 cycles after acceptance.
    auto_ret = 1'b1;
    start_run(8, 29'h100, 29'h40, 0);
    run_until_done("rd_done", 60);
    check("rd_count", 64'(log_n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd_addr%0d", i), 64'(log_addr[i]), 64'(29'h100 + 29'h40 * i));
      check($sformatf("rd_cyc%0d", i), 64'(log_cyc[i]), 64'(start_cyc + 1 + i));
    end
    check("rd_sent", 64'(reads_sent_o), 64'd8);
    check("rd_recv", 64'(reads_recv_o), 64'd8);
    check("rd_wsent", 64'(writes_sent_o), 64'd0);
    check("rd_cycles", 64'(cycles_o), 64'd13);
    check("rd_err", 64'(error_o), 64'd0);

    // Write interleave: every 4th request is a write.
    start_run(8, 29'h0, 29'h8, 4);
    run_until_done("wi_done", 60);
    for (int i = 0; i < 8; i++)
      check($sformatf("wi_type%0d", i), 64'(log_wr[i]), 64'((i == 3 || i == 7) ? 1 : 0));
    check("wi_wsent", 64'(writes_sent_o), 64'd2);
    check("wi_rsent", 64'(reads_sent_o), 64'd6);
    check("wi_recv", 64'(reads_recv_o), 64'd6);
    check("wi_cycles", 64'(cycles_o), 64'd12);

    // Held request: yumi low keeps address and type; write_every=1 makes all writes.
    yumi_i = 1'b0;
    start_run(2, 29'h80, 29'h10, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold_v%0d", i), 64'(v_o), 64'd1);
      check($sformatf("hold_addr%0d", i), 64'(ch_addr_o), 64'h80);
      check($sformatf("hold_wr%0d", i), 64'(write_not_read_o), 64'd1);
      step();
    end
    yumi_i = 1'b1;
    run_until_done("hold_done", 20);
    check("hold_addr_b", 64'(log_addr[1]), 64'h90);
    check("hold_wsent", 64'(writes_sent_o), 64'd2);
    check("hold_rsent", 64'(reads_sent_o), 64'd0);
    check("hold_cycles", 64'(cycles_o), 64'd5);

    // Address wrap modulo 2^29.
    start_run(3, 29'h1FFFFFC0, 29'h40, 0);
    run_until_done("wrap_done", 40);
    check("wrap_a0", 64'(log_addr[0]), 64'h1FFFFFC0);
    check("wrap_a1", 64'(log_addr[1]), 64'h0);
    check("wrap_a2", 64'(log_addr[2]), 64'h40);

    // Credit limit on the 4-credit instance: no returns, then one return.
    num_req_i = 10; base_addr_i = '0; stride_i = 29'h4; write_every_i = 0;
    c_acc = 0;
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("cr_acc4", 64'(c_acc), 64'd4);
    check("cr_v_off", 64'(c_v), 64'd0);
    check("cr_busy", 64'(c_busy), 64'd1);
    c_data_v = 1'b1;
    step();
    c_data_v = 1'b0;
    check("cr_v_on", 64'(c_v), 64'd1);
    step();
    check("cr_v_off2", 64'(c_v), 64'd0);
    step(); step(); step();
    check("cr_acc5", 64'(c_acc), 64'd5);
    check("cr_recv", 64'(c_reads_recv), 64'd1);
    check("cr_err", 64'(c_error), 64'd0);

    // Reset mid-operation: immediate return to reset values; stale returns flag error.
    start_run(8, 29'h200, 29'h40, 0);
    step(); step(); step();
    reset_i = 1'b1;
    #1;
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_addr", 64'(ch_addr_o), 64'd0);
    check("rst_rsent", 64'(reads_sent_o), 64'd0);
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("rst_stale_err", 64'(error_o), 64'd1);
    check("rst_stale_recv", 64'(reads_recv_o), 64'd3);
    check("rst_done", 64'(done_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
